// File: rtl/vga_tile_mem_arbiter.sv
// Single-port tile-map RAM scheduler: fixed video prefetch slots from the raster
// counters take priority, every other cycle goes round-robin to writers A and B.
module vga_tile_mem_arbiter #(
    parameter int H_VIS = 640,
    parameter int V_VIS = 480,
    parameter int H_TOT = 800,
    parameter int V_TOT = 525,
    parameter int COLS  = 80,
    parameter int AW    = 13,
    parameter int DW    = 8
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic [9:0]    h,
    input  logic [9:0]    v,
    input  logic          wra_req,
    input  logic [AW-1:0] wra_addr,
    input  logic [DW-1:0] wra_data,
    output logic          wra_ack,
    input  logic          wrb_req,
    input  logic [AW-1:0] wrb_addr,
    input  logic [DW-1:0] wrb_data,
    output logic          wrb_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] vid_tile,
    output logic [6:0]    vid_col,
    output logic [5:0]    vid_row,
    output logic          vid_valid,
    output logic          wr_err
);

    localparam logic [9:0]    H_LAST  = 10'(H_VIS - 16);
    localparam logic [9:0]    H_PREF  = 10'(H_TOT - 8);
    localparam logic [9:0]    V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0]    V_VIS_W = 10'(V_VIS);
    localparam logic [AW-1:0] N_TILES = AW'(COLS * (V_VIS / 8));

    // row*80 built from two shifts so no multiplier is needed
    function automatic logic [AW-1:0] tile_addr(input logic [9:0] line, input logic [6:0] col);
        logic [AW-1:0] row;
        row = AW'(line >> 3);
        return (row << 6) + (row << 4) + AW'(col);
    endfunction

    logic          slot_en;
    logic [6:0]    slot_col;
    logic [9:0]    slot_line;
    logic          sel_a, sel_b, wr_ok, favor_b;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          vld_p0, vld_p1;
    logic [6:0]    col_p0, col_p1;
    logic [5:0]    row_p0, row_p1;

    always_comb begin
        slot_en   = 1'b0;
        slot_col  = '0;
        slot_line = '0;
        if (h[2:0] == 3'd0 && h <= H_LAST && v < V_VIS_W) begin
            slot_en   = 1'b1;
            slot_col  = h[9:3] + 7'd1;
            slot_line = v;
        end else if (h == H_PREF) begin
            slot_line = (v == V_LAST) ? 10'd0 : v + 10'd1;
            slot_en   = (slot_line < V_VIS_W);
        end
    end

    always_comb begin
        sel_a   = !slot_en && wra_req && (!wrb_req || !favor_b);
        sel_b   = !slot_en && wrb_req && !sel_a;
        wr_addr = sel_b ? wrb_addr : wra_addr;
        wr_data = sel_b ? wrb_data : wra_data;
        wr_ok   = (wr_addr < N_TILES);
    end

    // Stage p0: issue to RAM; p1: RAM access; output stage captures read data
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wra_ack   <= 1'b0;
            wrb_ack   <= 1'b0;
            wr_err    <= 1'b0;
            favor_b   <= 1'b0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vid_valid <= 1'b0;
            vid_tile  <= '0;
            vid_col   <= '0;
            vid_row   <= '0;
        end else begin
            mem_we    <= 1'b0;
            wra_ack   <= sel_a;
            wrb_ack   <= sel_b;
            vld_p0    <= slot_en;
            vld_p1    <= vld_p0;
            vid_valid <= vld_p1;
            if (slot_en) begin
                mem_addr <= tile_addr(slot_line, slot_col);
            end else if (sel_a || sel_b) begin
                favor_b <= sel_a;
                if (wr_ok) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end
            if (vld_p1) begin
                vid_tile <= mem_rdata;
                vid_col  <= col_p1;
                vid_row  <= row_p1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        col_p0 <= slot_col;
        row_p0 <= 6'(slot_line >> 3);
        col_p1 <= col_p0;
        row_p1 <= row_p0;
    end

endmodule
